// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and small op-classification helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> multiply/divide unit bundle: op and operands in, status and
// architectural HI/LO out.
interface mdu_if;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDOp, A, B, input start, busy, MDOut, HI, LO);
  modport slave  (input MDOp, A, B, output start, busy, MDOut, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational product / quotient-remainder for the four multi-cycle ops.
// A zero divisor hands back the current HI/LO so the commit is a no-op.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  assign signed_div = (op == MD_DIV);
  assign a_neg      = signed_div & a[31];
  assign b_neg      = signed_div & b[31];
  assign a_mag      = a_neg ? (~a + 32'd1) : a;
  assign b_mag      = b_neg ? (~b + 32'd1) : b;
  assign q_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs a fixed-latency busy window per
// multi-cycle op and commits the shadowed result as busy falls.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  md_state_e   state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] shadow_hi_reg, shadow_hi_next;
  logic [31:0] shadow_lo_reg, shadow_lo_next;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        start_w;

  mdu_calc u_calc (
    .op     (bus.MDOp),
    .a      (bus.A),
    .b      (bus.B),
    .cur_hi (hi_reg),
    .cur_lo (lo_reg),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  assign start_w   = is_long_op(bus.MDOp) && (state_reg == ST_IDLE);
  assign bus.start = start_w;
  assign bus.busy  = (state_reg == ST_RUN);
  assign bus.HI    = hi_reg;
  assign bus.LO    = lo_reg;

  // Reads see only the registered value; an MTHI/MTLO this cycle is not bypassed.
  always_comb begin
    bus.MDOut = 32'd0;
    if (bus.MDOp == MD_MFHI) bus.MDOut = hi_reg;
    else if (bus.MDOp == MD_MFLO) bus.MDOut = lo_reg;
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    shadow_hi_next = shadow_hi_reg;
    shadow_lo_next = shadow_lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_w) begin
          state_next     = ST_RUN;
          cnt_next       = is_div_op(bus.MDOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          shadow_hi_next = calc_hi;
          shadow_lo_next = calc_lo;
        end else if (bus.MDOp == MD_MTHI) begin
          hi_next = bus.A;
        end else if (bus.MDOp == MD_MTLO) begin
          lo_next = bus.A;
        end
      end
      ST_RUN: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_IDLE;
          hi_next    = shadow_hi_reg;
          lo_next    = shadow_lo_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      shadow_hi_reg <= 32'd0;
      shadow_lo_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      shadow_hi_reg <= shadow_hi_next;
      shadow_lo_reg <= shadow_lo_next;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes per-cycle expectations from an
// arithmetic reference model, a negedge monitor pops and compares.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    int          cyc;
    logic        start;
    logic        busy;
    logic [31:0] mdout;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mdu_if bus();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc_no = 0;

  // reference architectural state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_pend_hi = 32'd0;
  logic [31:0] m_pend_lo = 32'd0;
  int          m_left = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("start", e.cyc, {31'd0, bus.start}, {31'd0, e.start});
      chk("busy",  e.cyc, {31'd0, bus.busy},  {31'd0, e.busy});
      chk("MDOut", e.cyc, bus.MDOut, e.mdout);
      chk("HI",    e.cyc, bus.HI,    e.hi);
      chk("LO",    e.cyc, bus.LO,    e.lo);
    end
  end

  // Results straight from the arithmetic definitions, using 64-bit integers.
  task automatic ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint          sp, sa, sb, sq, sr;
    longint unsigned up, ua, ub, uq, ur;
    rh = m_hi;
    rl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      4'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      4'd3: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
      4'd4: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; rh = ur[31:0]; rl = uq[31:0]; end
      default: ;
    endcase
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rst_n, input bit check);
    exp_t e;
    logic is_long;
    @(posedge clk);
    #1;
    bus.MDOp = op;
    bus.A    = a;
    bus.B    = b;
    reset    = rst_n;
    cyc_no++;
    is_long  = (op >= 4'd1) && (op <= 4'd4);
    e.cyc    = cyc_no;
    e.busy   = (m_left != 0);
    e.start  = is_long && (m_left == 0);
    e.mdout  = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    e.hi     = m_hi;
    e.lo     = m_lo;
    if (check) exp_q.push_back(e);
    if (op != 4'd0 || !rst_n)
      $display("cycle %0d: op=%0d A=%h B=%h reset=%b busy=%b", cyc_no, op, a, b, rst_n, e.busy);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
    end else if (is_long) begin
      ref_result(op, a, b, m_pend_hi, m_pend_lo);
      m_left = (op >= 4'd3) ? DIV_N : MULT_N;
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.MDOp = 4'd0;
    bus.A    = 32'd0;
    bus.B    = 32'd0;
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(2);

    step(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1);          // mult -2*3
    idle(7);
    step(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);   // multu
    idle(6);
    step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);          // div -7/2
    idle(10);
    step(4'd4, 32'd7, 32'd0, 1'b1, 1'b1);                 // divu by zero
    idle(11);
    step(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);   // div overflow case
    idle(11);
    step(4'd7, 32'h12345678, 32'd0, 1'b1, 1'b1);          // mthi
    step(4'd6, 32'd0, 32'd0, 1'b1, 1'b1);                 // mflo
    step(4'd5, 32'd0, 32'd0, 1'b1, 1'b1);                 // mfhi
    step(4'd1, 32'd9, 32'd11, 1'b1, 1'b1);                // mult, then collide
    idle(1);
    step(4'd1, 32'hAAAA, 32'd3, 1'b1, 1'b1);
    step(4'd8, 32'hAAAA, 32'd0, 1'b1, 1'b1);
    step(4'd5, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(4);
    step(4'd3, 32'd100, 32'd7, 1'b1, 1'b1);               // div, reset mid-flight
    idle(3);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd1, 32'd6, 32'd7, 1'b1, 1'b1);
    idle(12);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step(op, rnd_val(), rnd_val(), ($urandom_range(0, 80) != 0), 1'b1);
    end
    idle(12);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage, alongside the ALU. Consumes the MDOp decoded by the control unit for the instruction now in E, plus forwarded rs/rt operands.
- Handles mult, multu, div and divu as multi-cycle operations, and mfhi, mflo, mthi and mtlo as single-cycle accesses.
- Owns the HI/LO architectural registers.
- Drives busy/start to the hazard unit, which stalls D while any md-class instruction would collide.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- MDOp  in  4  E-stage md operation; NONE for bubbles and non-md instructions
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- start  out  1  combinational; high when MDOp is MULT, MULTU, DIV or DIVU and busy=0
- busy  out  1  registered; high while a multi-cycle operation is in flight
- MDOut  out  32  combinational; HI when MDOp=MFHI, LO when MDOp=MFLO, else 0
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

Behaviour:
- MDOp encodings, in package order: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9..15 behave as NONE.
- Reset: sampled at posedge with reset=0. Clears HI, LO, busy, the cycle counter and the shadow result registers. Takes priority over every other event, including an operation in flight; a pending result is discarded.
- States:
  - IDLE (busy=0) and RUN (busy=1), with a 4-bit down-counter cnt.
- IDLE -> RUN: at posedge with start=1.
  - Latch the result into shadowHI/shadowLO, computed combinationally from A and B this cycle.
  - Load cnt = MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
- RUN:
  - Decrement cnt at each posedge.
  - At the posedge where cnt==1: HI<=shadowHI, LO<=shadowLO, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge, and the new HI/LO are visible the cycle busy falls.
- Arithmetic:
  - mult: 64-bit signed product, HI=[63:32], LO=[31:0].
  - multu: unsigned product, same split.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - A is the dividend and multiplicand; B is the divisor and multiplier.
- Division boundary cases:
  - Divisor 0: shadow registers take the current HI/LO, so HI/LO end unchanged; busy still runs DIV_CYCLES.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE: HI (or LO) <= A at the posedge, one cycle, the other register untouched.
- MFHI/MFLO: pure read, no state change. MDOut reflects the registered value, with no same-cycle bypass of an MTHI/MTLO.
- MDOp arriving while busy=1:
  - Any multi-cycle op: start=0, ignored.
  - MTHI/MTLO: ignored.
  - MFHI/MFLO: return the stale value.
  - The hazard unit stalls these cases; the unit itself never corrupts state.
- start is low while busy, so back-to-back starts are impossible. A new op may start on the cycle busy has just fallen.

Decomposition:
- Shared package (def.v): MDOp encodings (`MD_none ... `MD_mtlo) and default cycle counts.
- One natural sub-module, mdu_calc: combinational 64-bit product and quotient/remainder. It takes the op, A and B, and returns resHI/resLO including the zero-divisor rule.
- The mdu top keeps the counter, HI/LO and the shadow registers.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3:
  - start=1 in cycle 0, busy high in cycles 1..5, low in cycle 6.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 6.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=-7 (0xFFFFFFF9), B=2:
  - busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with divu, A=7, B=0: HI/LO unchanged, busy still 10 cycles.
- mthi, A=0x12345678, then mflo next cycle and mfhi after:
  - HI=0x12345678, LO unchanged.
  - MDOut=LO, then MDOut=0x12345678.
- Start mult; during busy cycle 2 drive MULT and MTLO with A=0xAAAA:
  - start=0 and LO unchanged in both cases.
  - Original result commits at cycle 6.
- Start div; pull reset low in busy cycle 4:
  - Next cycle busy=0, HI=LO=0, and the old result never appears.
  - A mult started immediately after reset completes normally.
